ita_step_sequencer: RTL and testbench
=====================================

Name: ita_step_sequencer

Overview:
Parametrised multi-head step sequencer for ITA. It latches one layer configuration (layer type and tile counts) and walks the step sequence for that layer. For attention this is Q, K, V, QK, AV, OW, repeated per head. For feedforward it is F1, F2; for linear it is a single MatMul. Each tile is issued to the datapath controller over a valid/ready handshake, tagged with step, head, tile coordinates and requant-constant index. It generalises the fixed single-head step enumeration to NumHeads heads and runtime tile bounds.

Parameters:
NumHeads, 1, attention heads sequenced per Attention layer (>=1)
TileWidth, 16, width of each tile-count input and coordinate counter
HeadWidth, idx_width(NumHeads), width of head_o (1 when NumHeads=1)
NumRequantConsts, 8, entries in the requant constant array; requant_idx_o indexes it

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start request; honoured only in IDLE
layer_i  in  2  0=Attention, 1=Feedforward, 2=Linear, 3=illegal
tile_s_i  in  TileWidth  sequence tile count
tile_e_i  in  TileWidth  embedding tile count
tile_p_i  in  TileWidth  projection tile count
tile_f_i  in  TileWidth  feedforward tile count (used only by Feedforward)
busy_o  out  1  config latched, sequencing in progress
done_o  out  1  one-cycle pulse after last tile accepted
error_o  out  1  one-cycle pulse on rejected start
tile_valid_o  out  1  tile descriptor valid
tile_ready_i  in  1  consumer accepts descriptor
step_o  out  4  step code: Idle=0,Q=1,K=2,V=3,QK=4,AV=5,OW=6,F1=7,F2=8,MatMul=9
head_o  out  HeadWidth  current head
requant_idx_o  out  3  Q..OW=0..5, F1=6, F2=7, MatMul=0
tile_outer_o  out  TileWidth  outer coordinate
tile_mid_o  out  TileWidth  middle coordinate
tile_inner_o  out  TileWidth  inner (reduction) coordinate, fastest-varying
tile_last_o  out  1  descriptor is last tile of its step

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset values: all outputs 0, step_o=Idle, FSM=IDLE. Reset mid-run aborts immediately and produces no done_o.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: start_i=1 with legal layer_i and all used tile counts nonzero.
  - Config is latched on that edge; inputs are ignored afterwards.
  - busy_o and tile_valid_o rise on the next cycle, with coordinates 0 and head 0.
  - First step: Q (Attention), F1 (Feedforward) or MatMul (Linear).
- Start rejection (IDLE): layer_i=3, or any used tile count =0.
  - Used counts: Attention s,e,p; Feedforward s,e,f; Linear s,e,p.
  - Result: error_o pulses the next cycle, FSM stays IDLE.
- Start ignored while not IDLE; error_o is not pulsed.
- Per-step bounds (outer, mid, inner):
  - Q, K, V: (s, p, e)
  - QK: (s, s, p)
  - AV: (s, p, s)
  - OW: (s, e, p)
  - F1: (s, f, e)
  - F2: (s, e, f)
  - MatMul: (s, p, e)
- Handshake:
  - Descriptor is held stable while tile_valid_o=1 and tile_ready_i=0.
  - Advance happens only on valid&&ready.
  - tile_valid_o stays high between tiles and across step boundaries, so one tile per cycle when ready is held high.
- Advance order on each accepted tile:
  - inner+1; on inner wrap, mid+1; on mid wrap, outer+1.
  - On outer wrap, go to the next step. Attention: OW -> Q of head+1; OW of head NumHeads-1 ends the run. Feedforward: F1 -> F2 ends. Linear: MatMul ends.
  - Counters reset to 0 at every step change.
- tile_last_o = all three coordinates at (bound-1).
- Run end: after the final accepted tile, FSM enters DONE for one cycle.
  - In DONE: done_o=1, busy_o=0, tile_valid_o=0, step_o=Idle.
  - Next cycle returns to IDLE.
  - start_i during DONE is ignored.
- Coordinate compares are equality on TileWidth bits; the tile counts are unsigned.
- No arithmetic products; counters never exceed bound-1.

Test Plan:
- Attention, NumHeads=2, s=e=p=1, ready=1, start at cycle 0 -> 12 descriptors, cycles 1..12: Q,K,V,QK,AV,OW head0 then head1. tile_last_o=1 on each. done_o at cycle 13; busy_o low at 13.
- Feedforward, s=2,e=1,f=3 -> F1 6 tiles: (o,m,i)=(0,0,0),(0,1,0),(0,2,0),(1,0,0),(1,1,0),(1,2,0), requant_idx_o=6. Then F2 6 tiles with (o,m,i) over (2,1,3), inner fastest, requant_idx_o=7. One done_o pulse.
- Linear s=1,p=1,e=4, tile_ready_i toggling 1,0,0,1,... -> descriptor stable during ready=0, exactly 4 handshakes, inner 0..3. step_o=9 and requant_idx_o=0 throughout. done_o one cycle after the 4th handshake.
- Start with tile_p_i=0 (Attention), or layer_i=3 -> error_o pulses one cycle after start, busy_o and tile_valid_o stay 0. A second start_i while busy is ignored with no error.
- rst_i asserted during QK of head 0 -> next cycle all outputs 0, no done_o. A fresh start then begins at Q, head 0, coordinates 0.

Source files
------------

// File: rtl/ita_step_sequencer.sv
// Multi-head ITA step sequencer: latches one layer configuration and issues every
// tile of every step (and head) to the datapath controller over valid/ready.
module ita_step_sequencer #(
    parameter int NumHeads         = 1,
    parameter int TileWidth        = 16,
    parameter int HeadWidth        = (NumHeads > 1) ? $clog2(NumHeads) : 1,
    parameter int NumRequantConsts = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [1:0]                          layer_i,
    input  logic [TileWidth-1:0]                tile_s_i,
    input  logic [TileWidth-1:0]                tile_e_i,
    input  logic [TileWidth-1:0]                tile_p_i,
    input  logic [TileWidth-1:0]                tile_f_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                error_o,
    output logic                                tile_valid_o,
    input  logic                                tile_ready_i,
    output logic [3:0]                          step_o,
    output logic [HeadWidth-1:0]                head_o,
    output logic [$clog2(NumRequantConsts)-1:0] requant_idx_o,
    output logic [TileWidth-1:0]                tile_outer_o,
    output logic [TileWidth-1:0]                tile_mid_o,
    output logic [TileWidth-1:0]                tile_inner_o,
    output logic                                tile_last_o
);
    localparam int RqWidth = $clog2(NumRequantConsts);

    localparam logic [3:0] STEP_IDLE = 4'd0;
    localparam logic [3:0] STEP_Q    = 4'd1;
    localparam logic [3:0] STEP_K    = 4'd2;
    localparam logic [3:0] STEP_V    = 4'd3;
    localparam logic [3:0] STEP_QK   = 4'd4;
    localparam logic [3:0] STEP_AV   = 4'd5;
    localparam logic [3:0] STEP_OW   = 4'd6;
    localparam logic [3:0] STEP_F1   = 4'd7;
    localparam logic [3:0] STEP_F2   = 4'd8;
    localparam logic [3:0] STEP_MM   = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             step_q, step_d;
    logic [HeadWidth-1:0]   head_q, head_d;
    logic [TileWidth-1:0]   outer_q, outer_d, mid_q, mid_d, inner_q, inner_d;
    logic [TileWidth-1:0]   s_q, s_d, e_q, e_d, p_q, p_d, f_q, f_d;
    logic                   error_q, error_d;

    logic [TileWidth-1:0]   bnd_mid, bnd_inner;
    logic                   outer_end, mid_end, inner_end, head_end;
    logic                   start_legal;
    logic [3:0]             first_step;
    logic                   run;

    // Mid/inner bounds per step; the outer bound is always the sequence count.
    always_comb begin
        bnd_mid   = p_q;
        bnd_inner = e_q;
        case (step_q)
            STEP_QK: begin bnd_mid = s_q; bnd_inner = p_q; end
            STEP_AV: begin bnd_mid = p_q; bnd_inner = s_q; end
            STEP_OW: begin bnd_mid = e_q; bnd_inner = p_q; end
            STEP_F1: begin bnd_mid = f_q; bnd_inner = e_q; end
            STEP_F2: begin bnd_mid = e_q; bnd_inner = f_q; end
            default: begin bnd_mid = p_q; bnd_inner = e_q; end
        endcase
    end

    assign outer_end = (outer_q == s_q - 1'b1);
    assign mid_end   = (mid_q == bnd_mid - 1'b1);
    assign inner_end = (inner_q == bnd_inner - 1'b1);
    assign head_end  = (head_q == HeadWidth'(NumHeads - 1));

    always_comb begin
        start_legal = (layer_i != 2'd3) && (tile_s_i != '0) && (tile_e_i != '0) &&
                      ((layer_i == 2'd1) ? (tile_f_i != '0) : (tile_p_i != '0));
        case (layer_i)
            2'd0:    first_step = STEP_Q;
            2'd1:    first_step = STEP_F1;
            default: first_step = STEP_MM;
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        head_d  = head_q;
        outer_d = outer_q;
        mid_d   = mid_q;
        inner_d = inner_q;
        s_d     = s_q;
        e_d     = e_q;
        p_d     = p_q;
        f_d     = f_q;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (start_legal) begin
                        state_d = S_RUN;
                        step_d  = first_step;
                        head_d  = '0;
                        outer_d = '0;
                        mid_d   = '0;
                        inner_d = '0;
                        s_d     = tile_s_i;
                        e_d     = tile_e_i;
                        p_d     = tile_p_i;
                        f_d     = tile_f_i;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (tile_ready_i) begin
                    inner_d = inner_q + 1'b1;
                    if (inner_end) begin
                        inner_d = '0;
                        mid_d   = mid_q + 1'b1;
                        if (mid_end) begin
                            mid_d   = '0;
                            outer_d = outer_q + 1'b1;
                            if (outer_end) begin
                                outer_d = '0;
                                // Q..OW and F1->F2 are consecutive codes.
                                case (step_q)
                                    STEP_OW: begin
                                        if (head_end) begin
                                            state_d = S_DONE;
                                            step_d  = STEP_IDLE;
                                        end else begin
                                            step_d = STEP_Q;
                                            head_d = head_q + 1'b1;
                                        end
                                    end
                                    STEP_F2, STEP_MM: begin
                                        state_d = S_DONE;
                                        step_d  = STEP_IDLE;
                                    end
                                    default: step_d = step_q + 4'd1;
                                endcase
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                head_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= STEP_IDLE;
            head_q  <= '0;
            outer_q <= '0;
            mid_q   <= '0;
            inner_q <= '0;
            s_q     <= '0;
            e_q     <= '0;
            p_q     <= '0;
            f_q     <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            head_q  <= head_d;
            outer_q <= outer_d;
            mid_q   <= mid_d;
            inner_q <= inner_d;
            s_q     <= s_d;
            e_q     <= e_d;
            p_q     <= p_d;
            f_q     <= f_d;
            error_q <= error_d;
        end
    end

    assign run          = (state_q == S_RUN);
    assign busy_o       = run;
    assign tile_valid_o = run;
    assign done_o       = (state_q == S_DONE);
    assign error_o      = error_q;
    assign step_o       = run ? step_q : STEP_IDLE;
    assign head_o       = run ? head_q : '0;
    assign tile_outer_o = run ? outer_q : '0;
    assign tile_mid_o   = run ? mid_q : '0;
    assign tile_inner_o = run ? inner_q : '0;
    assign tile_last_o  = run && outer_end && mid_end && inner_end;

    always_comb begin
        requant_idx_o = '0;
        if (run) begin
            case (step_q)
                STEP_Q, STEP_K, STEP_V, STEP_QK, STEP_AV, STEP_OW:
                    requant_idx_o = RqWidth'(step_q - 4'd1);
                STEP_F1: requant_idx_o = RqWidth'(6);
                STEP_F2: requant_idx_o = RqWidth'(7);
                default: requant_idx_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ita_step_sequencer.sv
// Bench for ita_step_sequencer: expected descriptor streams come from nested loops
// over heads/steps/coordinates, compared against the DUT under random back-pressure.
module tb_ita_step_sequencer;
    localparam int NH = 2;
    localparam int TW = 16;
    localparam int HW = 1;

    logic          clk_i = 1'b0;
    logic          rst_i, start_i, tile_ready_i;
    logic [1:0]    layer_i;
    logic [TW-1:0] tile_s_i, tile_e_i, tile_p_i, tile_f_i;
    logic          busy_o, done_o, error_o, tile_valid_o, tile_last_o;
    logic [3:0]    step_o;
    logic [HW-1:0] head_o;
    logic [2:0]    requant_idx_o;
    logic [TW-1:0] tile_outer_o, tile_mid_o, tile_inner_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int step; int head; int o; int m; int i; int last; int rq;
    } desc_t;
    desc_t exp_q[$];

    ita_step_sequencer #(.NumHeads(NH), .TileWidth(TW), .HeadWidth(HW), .NumRequantConsts(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .layer_i(layer_i),
        .tile_s_i(tile_s_i), .tile_e_i(tile_e_i), .tile_p_i(tile_p_i), .tile_f_i(tile_f_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
        .step_o(step_o), .head_o(head_o), .requant_idx_o(requant_idx_o),
        .tile_outer_o(tile_outer_o), .tile_mid_o(tile_mid_o), .tile_inner_o(tile_inner_o),
        .tile_last_o(tile_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full expected tile list for one layer, straight from the step/bound table.
    task automatic build(input int lay, input int s, input int e, input int p, input int f);
        int nh, first, cnt, bo, bm, bi, st;
        desc_t d;
        exp_q.delete();
        nh    = (lay == 0) ? NH : 1;
        first = (lay == 0) ? 1 : ((lay == 1) ? 7 : 9);
        cnt   = (lay == 0) ? 6 : ((lay == 1) ? 2 : 1);
        for (int h = 0; h < nh; h++) begin
            for (int k = 0; k < cnt; k++) begin
                st = first + k;
                bo = s;
                case (st)
                    4:       begin bm = s; bi = p; end
                    5:       begin bm = p; bi = s; end
                    6:       begin bm = e; bi = p; end
                    7:       begin bm = f; bi = e; end
                    8:       begin bm = e; bi = f; end
                    default: begin bm = p; bi = e; end
                endcase
                for (int o = 0; o < bo; o++)
                    for (int m = 0; m < bm; m++)
                        for (int i = 0; i < bi; i++) begin
                            d.step = st; d.head = h; d.o = o; d.m = m; d.i = i;
                            d.last = (o == bo - 1 && m == bm - 1 && i == bi - 1) ? 1 : 0;
                            d.rq   = (st <= 6) ? st - 1 : ((st == 7) ? 6 : ((st == 8) ? 7 : 0));
                            exp_q.push_back(d);
                        end
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_valid"}, tile_valid_o, 0);
        check({tag, "_step"}, step_o, 0);
        check({tag, "_last"}, tile_last_o, 0);
    endtask

    // rmode: 0 = ready always high, 1 = ready pattern 1,0,0,..., 2 = random ready.
    task automatic run_layer(input int lay, input int s, input int e, input int p,
                             input int f, input int rmode);
        desc_t d;
        int k, budget, ntiles;
        build(lay, s, e, p, f);
        ntiles = exp_q.size();
        @(negedge clk_i);
        start_i = 1'b1; layer_i = 2'(lay);
        tile_s_i = TW'(s); tile_e_i = TW'(e); tile_p_i = TW'(p); tile_f_i = TW'(f);
        tile_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 0;
        budget = 5000;
        while (exp_q.size() > 0 && budget > 0) begin
            d = exp_q[0];
            check("valid", tile_valid_o, 1);
            check("busy", busy_o, 1);
            check("done_in_run", done_o, 0);
            check("error_in_run", error_o, 0);
            check("step", step_o, d.step);
            check("head", head_o, d.head);
            check("outer", tile_outer_o, d.o);
            check("mid", tile_mid_o, d.m);
            check("inner", tile_inner_o, d.i);
            check("last", tile_last_o, d.last);
            check("requant", requant_idx_o, d.rq);
            case (rmode)
                0:       tile_ready_i = 1'b1;
                1:       tile_ready_i = (k % 3 == 0);
                default: tile_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (tile_ready_i) void'(exp_q.pop_front());
            // Inputs are not supposed to matter once the config is latched.
            start_i  = 1'($urandom_range(0, 1));
            layer_i  = 2'($urandom_range(0, 3));
            tile_s_i = TW'($urandom_range(0, 5));
            tile_e_i = TW'($urandom_range(0, 5));
            tile_p_i = TW'($urandom_range(0, 5));
            tile_f_i = TW'($urandom_range(0, 5));
            k++;
            budget--;
            @(negedge clk_i);
        end
        check("run_budget", (budget > 0) ? 32'd1 : 32'd0, 1);
        check("done_pulse", done_o, 1);
        check("done_error", error_o, 0);
        check_quiet("done");
        $display("run layer=%0d s=%0d e=%0d p=%0d f=%0d rmode=%0d tiles=%0d cycles=%0d",
                 lay, s, e, p, f, rmode, ntiles, k);
        start_i = 1'b1; layer_i = 2'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        check("done_one_cycle", done_o, 0);
        check("idle_error", error_o, 0);
        check_quiet("idle");
    endtask

    task automatic start_err(input int lay, input int s, input int e, input int p, input int f);
        @(negedge clk_i);
        start_i = 1'b1; layer_i = 2'(lay);
        tile_s_i = TW'(s); tile_e_i = TW'(e); tile_p_i = TW'(p); tile_f_i = TW'(f);
        @(negedge clk_i);
        start_i = 1'b0;
        check("err_pulse", error_o, 1);
        check("err_done", done_o, 0);
        check_quiet("err");
        @(negedge clk_i);
        check("err_one_cycle", error_o, 0);
        check_quiet("err_after");
        $display("reject layer=%0d s=%0d e=%0d p=%0d f=%0d", lay, s, e, p, f);
    endtask

    initial begin
        int budget;
        rst_i = 1'b1; start_i = 1'b0; layer_i = 2'd0; tile_ready_i = 1'b0;
        tile_s_i = '0; tile_e_i = '0; tile_p_i = '0; tile_f_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_head", head_o, 0);
        check("rst_requant", requant_idx_o, 0);
        check("rst_coord", {tile_outer_o, tile_mid_o} | 32'(tile_inner_o), 0);
        check_quiet("rst");
        rst_i = 1'b0;

        run_layer(0, 1, 1, 1, 0, 0);
        run_layer(1, 2, 1, 0, 3, 0);
        run_layer(2, 1, 4, 1, 0, 1);
        start_err(0, 1, 1, 0, 1);
        start_err(3, 1, 1, 1, 1);
        start_err(1, 2, 2, 2, 0);

        // Reset during QK of head 0.
        @(negedge clk_i);
        start_i = 1'b1; layer_i = 2'd0; tile_ready_i = 1'b1;
        tile_s_i = 1; tile_e_i = 1; tile_p_i = 1; tile_f_i = 0;
        @(negedge clk_i);
        start_i = 1'b0;
        budget = 50;
        while (step_o != 4'd4 && budget > 0) begin
            budget--;
            @(negedge clk_i);
        end
        check("reach_qk", step_o, 4);
        check("qk_head", head_o, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_done", done_o, 0);
        check("abort_error", error_o, 0);
        check("abort_head", head_o, 0);
        check_quiet("abort");
        rst_i = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            check("post_abort_done", done_o, 0);
            check("post_abort_busy", busy_o, 0);
        end
        $display("reset abort during QK");
        run_layer(0, 1, 1, 1, 0, 0);

        for (int r = 0; r < 8; r++)
            run_layer($urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(1, 3),
                      $urandom_range(1, 3), $urandom_range(1, 3), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
